reg_inst_encoder: RTL and testbench
===================================

Name: reg_inst_encoder

Overview:
- Inverse of the R-type decode path: packs {alu_control, rs1, rs2, rd} into a 32-bit RV32I R-type instruction word (opcode 7'b0110011).
- Requests are buffered in a small FIFO and streamed out with the instruction-memory word address each word belongs to.
- Used by the test/boot loader to assemble programs into instruction memory, and as a golden encoder for decoder benches.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- ADDR_W, 32, width of the emitted byte address.
- BASE_ADDR, 32'h0, first address after reset or flush.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous clear of FIFO and address counter.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted when in_valid && in_ready.
- in_alu_control  input  5  operation code; same encoding the decoder produces.
- in_rs1  input  5  source register 1.
- in_rs2  input  5  source register 2.
- in_rd  input  5  destination register.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer takes head when out_valid && out_ready.
- out_instr  output  32  encoded instruction.
- out_addr  output  ADDR_W  byte address of out_instr.
- err  output  1  sticky: an illegal alu_control was accepted.
- err_cnt  output  8  count of illegal requests; saturates at 255.

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_instr=0, out_addr=BASE_ADDR, err=0, err_cnt=0, FIFO empty, address counter=BASE_ADDR.
- Encoding: out_instr = {funct7, rs2, rs1, funct3, rd, 7'b0110011}.
- alu_control to (funct3, funct7) mapping:
  - 1 ADD = 000, 0000000
  - 2 SUB = 000, 0100000
  - 3 XOR = 100, 0000000
  - 4 OR = 110, 0000000
  - 5 AND = 111, 0000000
  - 6 SLL = 001, 0000000
  - 7 SRL = 101, 0000000
  - 8 SRA = 101, 0100000
  - 9 SLT = 010, 0000000
  - 10 SLTU = 011, 0000000
- Illegal codes (0 and 11..31):
  - The request is accepted (in_ready is honoured) but nothing is pushed into the FIFO.
  - err is set; err_cnt increments.
  - The address counter does not advance.
- in_ready = !full. It depends only on registered state; there is no combinational path from out_ready. When full, in_ready=0 even if a pop happens in the same cycle.
- Push (legal accept):
  - The encoded word and the current address counter are written at the FIFO tail.
  - The address counter advances by 4, wrapping modulo 2^ADDR_W.
- Latency: a request accepted at edge N appears with out_valid=1 after edge N when the FIFO was empty. There is no same-cycle bypass.
- Pop: the head advances on out_valid && out_ready. out_instr and out_addr hold stable while out_valid && !out_ready.
- Simultaneous push and pop (not full): both occur, and the occupancy is unchanged.
- Pop on empty is ignored. Push on full cannot occur because in_ready=0.
- Ordering: strict FIFO. Addresses in the output stream are strictly consecutive, +4 per word.
- flush:
  - Empties the FIFO and sets the address counter to BASE_ADDR.
  - Has priority over any push or pop in the same cycle; the request offered that cycle is dropped.
  - err and err_cnt are kept.
- rst: has priority over flush. Asserted mid-stream, it discards all buffered entries; out_valid=0 on the next cycle.
- When out_valid=0, out_instr and out_addr hold the last popped values (0 and BASE_ADDR after reset). They must not be relied on.

Optional Feature:
- Macro: ENC_RD_X0_FILTER_EN.
- Defined: a legal request with in_rd==0 is accepted and discarded. No push, no address advance, and err/err_cnt are unaffected. It is a no-op write to x0.
- Not defined: rd==0 requests are encoded and pushed like any other.

Test Plan:
- Reset, then ADD rd=3 rs1=1 rs2=2, out_ready=1 -> one cycle later out_valid=1, out_instr=32'h002081B3, out_addr=0.
- SUB rd=5 rs1=6 rs2=7, then SRA rd=1 rs1=2 rs2=3 back-to-back -> words 32'h407302B3 @0 and 32'h403150B3 @4, in order.
- out_ready=0, push 4 legal requests -> in_ready=0 after the 4th. Head stays stable. Raise out_ready with in_valid high -> the 5th request is accepted one cycle after the first pop; addresses are 0, 4, 8, 12, 16.
- alu_control=0, then 11, then a legal ADD -> err=1, err_cnt=2; only the ADD is emitted, at address 0.
- Fill 3 entries, then assert flush together with in_valid and out_ready -> next cycle out_valid=0 and FIFO empty. The next push emits at address BASE_ADDR. err_cnt is unchanged.
- With ENC_RD_X0_FILTER_EN: ADD rd=0 then ADD rd=3 rs1=1 rs2=2 -> only 32'h002081B3 is emitted, at address 0. Without the macro: 32'h00208033 @0, then 32'h002081B3 @4.

Source files
------------

// File: rtl/reg_inst_encoder.sv
// Packs {alu_control, rs1, rs2, rd} into RV32I R-type words and streams them with their address.
// Optional macro ENC_RD_X0_FILTER_EN: legal requests writing x0 are accepted and discarded.
module reg_inst_encoder #(
  parameter int                 DEPTH     = 4,
  parameter int                 ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_alu_control,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [4:0]        in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic [7:0]        err_cnt
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [31:0]       instr_mem [DEPTH];
  logic [ADDR_W-1:0] addr_mem  [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]    count_q, count_d;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       last_instr_q;
  logic [ADDR_W-1:0] last_addr_q;
  logic              err_q;
  logic [7:0]        err_cnt_q;

  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        legal;
  logic        drop_x0;
  logic [31:0] enc_word;
  logic        accept, push, pop, illegal;

  // NOTE: every variable assigned in always_comb gets a default first, so no path infers a latch.
  always_comb begin
    funct3 = 3'b000;
    funct7 = 7'b0000000;
    legal  = 1'b1;
    case (in_alu_control)
      5'd1:  funct3 = 3'b000;
      5'd2:  funct7 = 7'b0100000;
      5'd3:  funct3 = 3'b100;
      5'd4:  funct3 = 3'b110;
      5'd5:  funct3 = 3'b111;
      5'd6:  funct3 = 3'b001;
      5'd7:  funct3 = 3'b101;
      5'd8:  begin funct3 = 3'b101; funct7 = 7'b0100000; end
      5'd9:  funct3 = 3'b010;
      5'd10: funct3 = 3'b011;
      default: legal = 1'b0;
    endcase
  end

  assign enc_word = {funct7, in_rs2, in_rs1, funct3, in_rd, 7'b0110011};

`ifdef ENC_RD_X0_FILTER_EN
  assign drop_x0 = (in_rd == 5'd0);
`else
  assign drop_x0 = 1'b0;
`endif

  // in_ready and out_valid come straight from registered occupancy: no path from out_ready.
  assign in_ready  = (count_q != DEPTH[PTR_W:0]);
  assign out_valid = (count_q != '0);
  assign accept    = in_valid && in_ready;
  assign push      = accept && legal && !drop_x0;
  assign illegal   = accept && !legal;
  assign pop       = out_valid && out_ready;

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + (PTR_W+1)'(1);
    else if (pop && !push) count_d = count_q - (PTR_W+1)'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      addr_q       <= BASE_ADDR;
      last_instr_q <= '0;
      last_addr_q  <= BASE_ADDR;
      err_q        <= 1'b0;
      err_cnt_q    <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      addr_q   <= BASE_ADDR;
    end else begin
      count_q <= count_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        addr_q   <= addr_q + ADDR_W'(4);
      end
      if (pop) begin
        rd_ptr_q     <= rd_ptr_q + PTR_W'(1);
        last_instr_q <= instr_mem[rd_ptr_q];
        last_addr_q  <= addr_mem[rd_ptr_q];
      end
      if (illegal) begin
        err_q <= 1'b1;
        if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  // NOTE: storage is not reset; occupancy gates its visibility, which keeps it plain RAM.
  always_ff @(posedge clk) begin
    if (!rst && !flush && push) begin
      instr_mem[wr_ptr_q] <= enc_word;
      addr_mem[wr_ptr_q]  <= addr_q;
    end
  end

  // Empty FIFO shows the last popped word; only meaningful when out_valid is high.
  assign out_instr = out_valid ? instr_mem[rd_ptr_q] : last_instr_q;
  assign out_addr  = out_valid ? addr_mem[rd_ptr_q]  : last_addr_q;
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_reg_inst_encoder.sv
// Self-checking bench for reg_inst_encoder: vector table, scoreboard queue and directed corner sequences.
module tb_reg_inst_encoder;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, err;
  logic [4:0]  in_alu_control, in_rs1, in_rs2, in_rd;
  logic [31:0] out_instr, out_addr;
  logic [7:0]  err_cnt;

  reg_inst_encoder #(.DEPTH(DEPTH), .ADDR_W(32), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_control(in_alu_control), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr),
    .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  alu;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] word;
    logic        legal;
  } vec_t;

  typedef struct {
    logic [31:0] word;
    logic [31:0] addr;
  } exp_t;

  vec_t        vecs [10];
  exp_t        sb [$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] m_addr   = 32'h0;
  int          m_err_cnt = 0;
  logic [31:0] exp_word;
  logic        exp_legal;
  logic [31:0] last_pop_addr = 32'hFFFF_FFFF;
  int          pop_cnt = 0;
  bit          x0_filter;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] alu, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [31:0] word, input logic legal);
    in_valid = 1'b1; in_alu_control = alu; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
    exp_word = word; exp_legal = legal;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // Evaluates the handshakes that the next rising edge will perform, then advances past it.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    if (rst) begin
      sb.delete(); m_addr = 32'h0; m_err_cnt = 0;
    end else if (flush) begin
      sb.delete(); m_addr = 32'h0;
    end else begin
      check("out_valid_vs_model", {31'b0, out_valid}, {31'b0, sb.size() != 0});
      check("in_ready_vs_model", {31'b0, in_ready}, {31'b0, sb.size() < DEPTH});
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("pop_with_empty_model", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("stream_instr", out_instr, e.word);
          check("stream_addr", out_addr, e.addr);
          last_pop_addr = out_addr;
          pop_cnt++;
        end
      end
      if (in_valid && in_ready) begin
        if (!exp_legal) begin
          if (m_err_cnt < 255) m_err_cnt++;
        end else if (!(x0_filter && in_rd == 5'd0)) begin
          e.word = exp_word; e.addr = m_addr;
          sb.push_back(e);
          m_addr = m_addr + 32'd4;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    flush = 1'b1; cycle(); flush = 1'b0;
  endtask

  initial begin
`ifdef ENC_RD_X0_FILTER_EN
    x0_filter = 1'b1;
`else
    x0_filter = 1'b0;
`endif
    vecs[0] = '{5'd2,  5'd6,  5'd7,  5'd5,  32'h407302B3, 1'b1};
    vecs[1] = '{5'd8,  5'd2,  5'd3,  5'd1,  32'h403150B3, 1'b1};
    vecs[2] = '{5'd1,  5'd1,  5'd2,  5'd3,  32'h002081B3, 1'b1};
    vecs[3] = '{5'd3,  5'd11, 5'd12, 5'd10, 32'h00C5C533, 1'b1};
    vecs[4] = '{5'd4,  5'd31, 5'd31, 5'd31, 32'h01FFEFB3, 1'b1};
    vecs[5] = '{5'd5,  5'd8,  5'd16, 5'd4,  32'h01047233, 1'b1};
    vecs[6] = '{5'd6,  5'd1,  5'd30, 5'd9,  32'h01E094B3, 1'b1};
    vecs[7] = '{5'd7,  5'd3,  5'd4,  5'd2,  32'h0041D133, 1'b1};
    vecs[8] = '{5'd9,  5'd18, 5'd19, 5'd17, 32'h013928B3, 1'b1};
    vecs[9] = '{5'd10, 5'd21, 5'd22, 5'd20, 32'h016ABA33, 1'b1};

    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b0; in_alu_control = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
    exp_word = '0; exp_legal = 1'b0;
    repeat (2) cycle();
    rst = 1'b0;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_instr", out_instr, 32'h0);
    check("rst_out_addr", out_addr, 32'h0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_err_cnt", {24'b0, err_cnt}, 32'd0);

    // Illegal codes 0 and 11, then ADD: only the ADD emerges, at address 0, one cycle later.
    out_ready = 1'b1;
    drive(5'd0,  5'd1, 5'd2, 5'd3, 32'h0, 1'b0); cycle();
    drive(5'd11, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0); cycle();
    drive(5'd1,  5'd1, 5'd2, 5'd3, 32'h002081B3, 1'b1); cycle();
    idle();
    check("lat_out_valid", {31'b0, out_valid}, 32'd1);
    check("lat_out_instr", out_instr, 32'h002081B3);
    check("lat_out_addr", out_addr, 32'h0);
    check("illegal_err", {31'b0, err}, 32'd1);
    check("illegal_err_cnt", {24'b0, err_cnt}, 32'd2);
    cycle();

    // Full mapping table, streamed back-to-back from address 0.
    do_flush();
    check("flush_keeps_err_cnt", {24'b0, err_cnt}, 32'd2);
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].alu, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].word, vecs[i].legal);
      cycle();
    end
    idle();
    repeat (3) cycle();
    check("table_last_addr", last_pop_addr, 32'd36);

    // Backpressure: fill, hold head stable, then a fifth request enters after the first pop.
    do_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(vecs[i].alu, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].word, 1'b1);
      cycle();
    end
    check("full_in_ready", {31'b0, in_ready}, 32'd0);
    drive(vecs[4].alu, vecs[4].rs1, vecs[4].rs2, vecs[4].rd, vecs[4].word, 1'b1);
    repeat (2) cycle();
    check("stall_head_instr", out_instr, 32'h407302B3);
    check("stall_head_addr", out_addr, 32'h0);
    out_ready = 1'b1;
    check("pop_cycle_in_ready", {31'b0, in_ready}, 32'd0);
    cycle();
    check("after_pop_in_ready", {31'b0, in_ready}, 32'd1);
    cycle();
    idle();
    repeat (6) cycle();
    check("fifth_addr", last_pop_addr, 32'd16);

    // Flush with push and pop offered in the same cycle.
    do_flush();
    out_ready = 1'b0;
    for (int i = 5; i < 8; i++) begin
      drive(vecs[i].alu, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].word, 1'b1);
      cycle();
    end
    drive(vecs[8].alu, vecs[8].rs1, vecs[8].rs2, vecs[8].rd, vecs[8].word, 1'b1);
    out_ready = 1'b1;
    do_flush();
    idle();
    check("flush_out_valid", {31'b0, out_valid}, 32'd0);
    check("flush_in_ready", {31'b0, in_ready}, 32'd1);
    check("flush_err_cnt", {24'b0, err_cnt}, 32'd2);
    drive(5'd1, 5'd1, 5'd2, 5'd3, 32'h002081B3, 1'b1); cycle();
    idle();
    check("post_flush_addr", out_addr, 32'h0);
    check("post_flush_instr", out_instr, 32'h002081B3);
    cycle();

    // x0 destination handling.
    do_flush();
    pop_cnt = 0;
    drive(5'd1, 5'd1, 5'd2, 5'd0, 32'h00208033, 1'b1); cycle();
    drive(5'd1, 5'd1, 5'd2, 5'd3, 32'h002081B3, 1'b1); cycle();
    idle();
    repeat (3) cycle();
    check("x0_pop_count", pop_cnt, x0_filter ? 32'd1 : 32'd2);
    check("x0_last_addr", last_pop_addr, x0_filter ? 32'd0 : 32'd4);

    // Reset mid-stream discards buffered words and clears error state.
    out_ready = 1'b0;
    drive(vecs[0].alu, vecs[0].rs1, vecs[0].rs2, vecs[0].rd, vecs[0].word, 1'b1); cycle();
    drive(vecs[1].alu, vecs[1].rs1, vecs[1].rs2, vecs[1].rd, vecs[1].word, 1'b1); cycle();
    rst = 1'b1; cycle(); rst = 1'b0;
    idle();
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_err", {31'b0, err}, 32'd0);
    check("midrst_err_cnt", {24'b0, err_cnt}, 32'd0);
    check("midrst_out_addr", out_addr, 32'h0);
    out_ready = 1'b1;
    repeat (2) cycle();

    check("scoreboard_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
